// File: rtl/pipeexe_md_pkg.sv
// Shared definitions for the EX stage with multiply/divide.
// Contents:
//   MD_*  : emdop operation codes seen on the ID/EX register
//   ALU_* : ealuc codes of the pipeline ALU
//   md_state_e : multiply/divide sequencer states
//   helper functions classifying an emdop code
package pipeexe_md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Operation that launches an iterative multiply or divide.
    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Operation that treats its operands as two's complement.
    function automatic logic is_md_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Operation that uses the divider datapath.
    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/pipeexe_md_mdu.sv
// pipe_mdu: iterative multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle on operand magnitudes (shift-add multiply,
// restoring divide); signs are applied on the final step.
// Ports:
//   clock, resetn   : clock, async active-low reset
//   emdop           : operation code (MD_*)
//   eflush          : abort the current operation / suppress start and mthi/mtlo
//   ea, eb          : operands (ea = dividend / mthi-mtlo source)
//   busy, done      : sequencer state decodes
//   hi, lo          : architectural HI/LO registers
module pipe_mdu import pipeexe_md_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [3:0]      emdop,
    input  logic            eflush,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_e         state_r;
    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r;
    logic [XLEN-1:0]   opnd_r;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   wrk_hi_r;   // upper product half or partial remainder
    logic [XLEN-1:0]   wrk_lo_r;   // multiplier bits or dividend/quotient bits
    logic [XLEN-1:0]   dvd_r;      // original dividend, returned in hi on divide-by-zero
    logic              is_div_r, neg_q_r, neg_r_r, dz_r;

    logic              start_s, sa_s, sb_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, ld_opnd_s, ld_lo_s;
    logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
    logic [XLEN-1:0]   nxt_hi_s, nxt_lo_s, quo_s, rem_s, res_hi_s, res_lo_s;
    logic [2*XLEN-1:0] prod_s;

    // Operand magnitudes and load values for a new operation
    always_comb begin
        start_s = is_md_start(emdop);
        sa_s    = is_md_signed(emdop) & ea[XLEN-1];
        sb_s    = is_md_signed(emdop) & eb[XLEN-1];
        if (sa_s) begin
            mag_a_s = -ea;
        end else begin
            mag_a_s = ea;
        end
        if (sb_s) begin
            mag_b_s = -eb;
        end else begin
            mag_b_s = eb;
        end
        // the divider shifts the dividend out of wrk_lo; the multiplier shifts the multiplier out
        if (is_md_div(emdop)) begin
            ld_opnd_s = mag_b_s;
            ld_lo_s   = mag_a_s;
        end else begin
            ld_opnd_s = mag_a_s;
            ld_lo_s   = mag_b_s;
        end
    end

    // One radix-2 step plus sign fixup of the step's outcome
    always_comb begin
        mul_sum_s  = {1'b0, wrk_hi_r} + (wrk_lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_sh_s   = {wrk_hi_r, wrk_lo_r[XLEN-1]};
        div_diff_s = div_sh_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[XLEN]) begin
                nxt_hi_s = div_diff_s[XLEN-1:0];
                nxt_lo_s = {wrk_lo_r[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi_s = div_sh_s[XLEN-1:0];
                nxt_lo_s = {wrk_lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi_s = mul_sum_s[XLEN:1];
            nxt_lo_s = {mul_sum_s[0], wrk_lo_r[XLEN-1:1]};
        end
        if (neg_q_r) begin
            prod_s = -{nxt_hi_s, nxt_lo_s};
            quo_s  = -nxt_lo_s;
        end else begin
            prod_s = {nxt_hi_s, nxt_lo_s};
            quo_s  = nxt_lo_s;
        end
        // remainder follows the dividend's sign
        if (neg_r_r) begin
            rem_s = -nxt_hi_s;
        end else begin
            rem_s = nxt_hi_s;
        end
        if (!is_div_r) begin
            res_hi_s = prod_s[2*XLEN-1:XLEN];
            res_lo_s = prod_s[XLEN-1:0];
        end else if (dz_r) begin
            res_hi_s = dvd_r;
            res_lo_s = {XLEN{1'b1}};
        end else begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end
    end

    // Sequencer, iteration registers and HI/LO
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CW{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            wrk_hi_r <= {XLEN{1'b0}};
            wrk_lo_r <= {XLEN{1'b0}};
            dvd_r    <= {XLEN{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (eflush) begin
                        state_r <= MD_IDLE;
                    end else if (start_s) begin
                        state_r  <= MD_BUSY;
                        cnt_r    <= {CW{1'b0}};
                        opnd_r   <= ld_opnd_s;
                        wrk_hi_r <= {XLEN{1'b0}};
                        wrk_lo_r <= ld_lo_s;
                        dvd_r    <= ea;
                        is_div_r <= is_md_div(emdop);
                        neg_q_r  <= sa_s ^ sb_s;
                        neg_r_r  <= sa_s;
                        dz_r     <= is_md_div(emdop) & (eb == {XLEN{1'b0}});
                    end else if (emdop == MD_MTHI) begin
                        hi_r <= ea;
                    end else if (emdop == MD_MTLO) begin
                        lo_r <= ea;
                    end else begin
                        state_r <= MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (eflush) begin
                        state_r <= MD_IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        wrk_hi_r <= nxt_hi_s;
                        wrk_lo_r <= nxt_lo_s;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= MD_DONE;
                            cnt_r   <= {CW{1'b0}};
                            hi_r    <= res_hi_s;
                            lo_r    <= res_lo_s;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                // the operation that just finished is still held in ID/EX; ignore it
                MD_DONE: begin
                    state_r <= MD_IDLE;
                end
                default: begin
                    state_r <= MD_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy = (state_r == MD_BUSY);
    assign done = (state_r == MD_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/pipeexe_md.sv
// pipeexe_md: EX stage. ALU with shift/immediate operand muxing, jal link
// address and destination forcing, plus an iterative multiply/divide unit
// whose stall request freezes the front of the pipe.
// Ports:
//   clock, resetn         : clock, async active-low reset
//   ealuc, ealuimm, eshift: ALU op, B=eimm select, A=eimm (shamt) select
//   ejal, epc4            : jal: result is epc4+LINK_OFS, destination LINK_REG
//   ea, eb, eimm          : register operands and extended immediate
//   ern0 / ern            : decoded / final destination register
//   emdop, eflush         : multiply/divide op, abort of the EX instruction
//   ealu                  : EX result to EX/MEM
//   estall                : stall request to the hazard unit
module pipeexe_md import pipeexe_md_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int RADDR    = 5,
    parameter int LINK_REG = 31,
    parameter int LINK_OFS = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [XLEN-1:0]  ea,
    input  logic [XLEN-1:0]  eb,
    input  logic [XLEN-1:0]  eimm,
    input  logic [XLEN-1:0]  epc4,
    input  logic [RADDR-1:0] ern0,
    input  logic [3:0]       emdop,
    input  logic             eflush,
    output logic [RADDR-1:0] ern,
    output logic [XLEN-1:0]  ealu,
    output logic             estall
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] alua_s, alub_s, alu_s, hi_s, lo_s;
    logic            busy_s, done_s, idle_s, start_s;

    pipe_mdu #(.XLEN(XLEN)) u_mdu (
        .clock  (clock),
        .resetn (resetn),
        .emdop  (emdop),
        .eflush (eflush),
        .ea     (ea),
        .eb     (eb),
        .busy   (busy_s),
        .done   (done_s),
        .hi     (hi_s),
        .lo     (lo_s)
    );

    // ALU operand selection
    always_comb begin
        if (eshift) begin
            alua_s = eimm;
        end else begin
            alua_s = ea;
        end
        if (ealuimm) begin
            alub_s = eimm;
        end else begin
            alub_s = eb;
        end
    end

    // ALU; shifts move B by the low bits of A
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (ealuc)
            ALU_ADD: alu_s = alua_s + alub_s;
            ALU_SUB: alu_s = alua_s - alub_s;
            ALU_AND: alu_s = alua_s & alub_s;
            ALU_OR:  alu_s = alua_s | alub_s;
            ALU_XOR: alu_s = alua_s ^ alub_s;
            ALU_LUI: alu_s = alub_s << (XLEN / 2);
            ALU_SLL: alu_s = alub_s << alua_s[SW-1:0];
            ALU_SRL: alu_s = alub_s >> alua_s[SW-1:0];
            ALU_SRA: alu_s = $signed(alub_s) >>> alua_s[SW-1:0];
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Result and destination selection
    always_comb begin
        if (ejal) begin
            ealu = epc4 + XLEN'(LINK_OFS);
        end else if (emdop == MD_MFHI) begin
            ealu = hi_s;
        end else if (emdop == MD_MFLO) begin
            ealu = lo_s;
        end else begin
            ealu = alu_s;
        end
        if (ejal) begin
            ern = RADDR'(LINK_REG);
        end else begin
            ern = ern0;
        end
    end

    // the launch cycle stalls combinationally so the operation is held in ID/EX
    assign idle_s  = ~busy_s & ~done_s;
    assign start_s = is_md_start(emdop);
    assign estall  = (start_s & idle_s & ~eflush) | busy_s;

endmodule

// File: tb/tb_pipeexe_md.sv
// Bench for pipeexe_md: a reference model (arithmetic on 64-bit integers and
// a countdown of busy cycles) checked every falling edge, plus directed
// vectors with hand-computed results. A second instance is built with XLEN=16.
module tb_pipeexe_md;
    import pipeexe_md_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  ealuc, emdop, emdop16;
    logic        ealuimm, eshift, ejal, eflush;
    logic [31:0] ea, eb, eimm, epc4, ealu;
    logic [15:0] ea16, eb16, eimm16, epc4_16, ealu16;
    logic [4:0]  ern0, ern, ern16;
    logic        estall, estall16;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int          m_busy = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

    always #5 clk = ~clk;

    pipeexe_md dut (
        .clock(clk), .resetn(rstn), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
        .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
        .emdop(emdop), .eflush(eflush), .ern(ern), .ealu(ealu), .estall(estall)
    );

    pipeexe_md #(.XLEN(16)) dut16 (
        .clock(clk), .resetn(rstn), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
        .ejal(ejal), .ea(ea16), .eb(eb16), .eimm(eimm16), .epc4(epc4_16), .ern0(ern0),
        .emdop(emdop16), .eflush(eflush), .ern(ern16), .ealu(ealu16), .estall(estall16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic md_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LUI: return {b[15:0], 16'h0000};
            ALU_SLL: return b << a[4:0];
            ALU_SRL: return b >> a[4:0];
            ALU_SRA: return 32'($signed(b) >>> a[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // {hi,lo} an operation must produce, from plain integer arithmetic
    function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return 64'(ua * ub);
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // model: result computed at launch, committed after 32 busy cycles
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (m_busy > 0) begin
            if (eflush) begin
                m_busy <= 0;
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!eflush) begin
            if (md_start(emdop)) begin
                {p_hi, p_lo} <= md_ref(emdop, ea, eb);
                m_busy <= 32;
            end else if (emdop == MD_MTHI) begin
                m_hi <= ea;
            end else if (emdop == MD_MTLO) begin
                m_lo <= ea;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] e_alu;
        logic        e_st;
        if (ejal) e_alu = epc4 + 32'd4;
        else if (emdop == MD_MFHI) e_alu = m_hi;
        else if (emdop == MD_MFLO) e_alu = m_lo;
        else e_alu = alu_ref(ealuc, eshift ? eimm : ea, ealuimm ? eimm : eb);
        e_st = (m_busy > 0) || (!m_done && md_start(emdop) && !eflush);
        chk("cyc ealu", ealu, e_alu);
        chk("cyc ern", ern, ejal ? 5'd31 : ern0);
        chk("cyc estall", estall, e_st);
    end

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        emdop = op; ea = a; eb = b; cyc = 0;
        #1;
        while (estall === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        tick();              // DONE -> IDLE with the op still held
        emdop = MD_NONE;
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
        emdop = MD_MFHI; #1;
        chk({nm, " mfhi"}, ealu, ehi);
        emdop = MD_MFLO; #1;
        chk({nm, " mflo"}, ealu, elo);
        emdop = MD_NONE; #1;
    endtask

    logic [3:0]  tv_op[6];
    logic [31:0] tv_a[6], tv_b[6], tv_hi[6], tv_lo[6];

    initial begin
        int cyc;
        tv_op[0] = MD_MULT;  tv_a[0] = 32'hFFFF_FFFD; tv_b[0] = 32'd7;          tv_hi[0] = 32'hFFFF_FFFF; tv_lo[0] = 32'hFFFF_FFEB;
        tv_op[1] = MD_MULTU; tv_a[1] = 32'hFFFF_FFFF; tv_b[1] = 32'hFFFF_FFFF; tv_hi[1] = 32'hFFFF_FFFE; tv_lo[1] = 32'd1;
        tv_op[2] = MD_DIV;   tv_a[2] = 32'hFFFF_FFF9; tv_b[2] = 32'd2;          tv_hi[2] = 32'hFFFF_FFFF; tv_lo[2] = 32'hFFFF_FFFD;
        tv_op[3] = MD_DIVU;  tv_a[3] = 32'd100;       tv_b[3] = 32'd7;          tv_hi[3] = 32'd2;         tv_lo[3] = 32'd14;
        tv_op[4] = MD_DIV;   tv_a[4] = 32'd5;         tv_b[4] = 32'd0;          tv_hi[4] = 32'd5;         tv_lo[4] = 32'hFFFF_FFFF;
        tv_op[5] = MD_DIV;   tv_a[5] = 32'h8000_0000; tv_b[5] = 32'hFFFF_FFFF; tv_hi[5] = 32'd0;         tv_lo[5] = 32'h8000_0000;

        rstn = 1'b0; ealuc = ALU_ADD; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0; eflush = 1'b0;
        ea = 32'd0; eb = 32'd0; eimm = 32'd0; epc4 = 32'd0; ern0 = 5'd9; emdop = MD_NONE;
        ea16 = 16'd0; eb16 = 16'd0; eimm16 = 16'd0; epc4_16 = 16'd0; emdop16 = MD_NONE;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("reset estall", estall, 1'b0);
        read_hilo("reset", 32'd0, 32'd0);
        tick();

        // ALU, operand muxes and jal
        ealuc = ALU_ADD; ea = 32'd5; eb = 32'd7; #1;
        chk("add ealu", ealu, 32'd12);
        chk("add ern", ern, 5'd9);
        tick();
        ejal = 1'b1; epc4 = 32'h100; #1;
        chk("jal ealu", ealu, 32'h104);
        chk("jal ern", ern, 5'd31);
        ejal = 1'b0; tick();
        ealuc = ALU_SUB; #1;
        chk("sub ealu", ealu, 32'hFFFF_FFFE);
        tick();
        ealuc = ALU_SLL; eshift = 1'b1; eimm = 32'd4; eb = 32'd1; #1;
        chk("sll shamt", ealu, 32'd16);
        eshift = 1'b0; tick();
        ealuc = ALU_SRA; ea = 32'd4; eb = 32'h8000_0000; #1;
        chk("sra ealu", ealu, 32'hF800_0000);
        tick();
        ealuc = ALU_ADD; ealuimm = 1'b1; ea = 32'd3; eimm = 32'h10; #1;
        chk("addi ealu", ealu, 32'h13);
        tick();
        ealuc = ALU_LUI; eimm = 32'h1234; #1;
        chk("lui ealu", ealu, 32'h1234_0000);
        ealuimm = 1'b0; ealuc = ALU_ADD; tick();

        // multiply / divide vectors
        for (int i = 0; i < 6; i++) begin
            run_md(tv_op[i], tv_a[i], tv_b[i], cyc);
            chk($sformatf("md%0d stall cycles", i), cyc, 33);
            read_hilo($sformatf("md%0d", i), tv_hi[i], tv_lo[i]);
            tick();
        end

        // mthi/mtlo, and eflush suppressing them
        emdop = MD_MTHI; ea = 32'hA5A5_A5A5; #1;
        chk("mthi no stall", estall, 1'b0);
        tick();
        emdop = MD_MTLO; ea = 32'h5A5A_5A5A; tick();
        emdop = MD_MTHI; ea = 32'hDEAD_BEEF; eflush = 1'b1; tick();
        eflush = 1'b0; emdop = MD_NONE;
        read_hilo("mthi", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        tick();

        // flush suppresses start; flush at cnt=10 aborts without touching hi/lo
        emdop = MD_DIVU; eflush = 1'b1; #1;
        chk("flush no start", estall, 1'b0);
        tick();
        eflush = 1'b0; emdop = MD_NONE; tick();
        emdop = MD_MULT; ea = 32'd123; eb = 32'd456;
        repeat (11) tick();
        chk("busy at cnt10", estall, 1'b1);
        eflush = 1'b1; tick();
        eflush = 1'b0; emdop = MD_NONE; #1;
        chk("flush idle", estall, 1'b0);
        read_hilo("flush", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        tick();

        // asynchronous reset in the middle of a divide
        emdop = MD_DIVU; ea = 32'd1000; eb = 32'd7;
        repeat (5) tick();
        #2;
        rstn = 1'b0; emdop = MD_NONE; #1;
        chk("arst estall", estall, 1'b0);
        tick();
        rstn = 1'b1;
        read_hilo("arst", 32'd0, 32'd0);
        tick();
        run_md(MD_DIVU, 32'd100, 32'd7, cyc);
        chk("post-reset stall cycles", cyc, 33);
        read_hilo("post-reset", 32'd2, 32'd14);
        tick();

        // XLEN=16 instance
        emdop16 = MD_DIVU; ea16 = 16'd1000; eb16 = 16'd7; cyc = 0; #1;
        while (estall16 === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        tick();
        emdop16 = MD_MFHI; #1;
        chk("x16 stall cycles", cyc, 17);
        chk("x16 mfhi", ealu16, 16'd6);
        emdop16 = MD_MFLO; #1;
        chk("x16 mflo", ealu16, 16'd142);
        emdop16 = MD_NONE;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
